// File: rtl/rf_16x_onehot_wr.sv
// 16-entry register file written by a one-hot decoder enable, with two registered
// read ports, same-edge write-to-read bypass and a sticky illegal-enable flag.
module rf_16x_onehot_wr #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [15:0]  R_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    input  logic [3:0]   rd_addr_a,
    input  logic [3:0]   rd_addr_b,
    input  logic         err_clr,
    output logic [W-1:0] rd_data_a,
    output logic [W-1:0] rd_data_b,
    output logic         rd_valid,
    output logic         wr_err
);

    // Read handshake: rd_en sampled high at an edge makes rd_valid high for exactly the
    // following cycle with fresh rd_data_a/b; there is no ready, the consumer must take it.

    logic [W-1:0] r_regs [16];
    logic [W-1:0] r_rd_data_a;
    logic [W-1:0] r_rd_data_b;
    logic         r_rd_valid;
    logic         r_wr_err;

    logic         w_multi_hot;
    logic [15:0]  w_we;
    logic [W-1:0] w_rd_a;
    logic [W-1:0] w_rd_b;

    // Any two set bits survive x & (x-1); zero and one-hot vectors do not.
    assign w_multi_hot = (R_en & (R_en - 16'd1)) != 16'd0;

    // Register r is driven by enable bit (r+1) mod 16, i.e. R_en rotated right by one.
    assign w_we = w_multi_hot ? 16'd0 : {R_en[0], R_en[15:1]};

    assign w_rd_a = w_we[rd_addr_a] ? wr_data : r_regs[rd_addr_a];
    assign w_rd_b = w_we[rd_addr_b] ? wr_data : r_regs[rd_addr_b];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (w_we[i]) begin
                    r_regs[i] <= wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data_a <= '0;
            r_rd_data_b <= '0;
            r_rd_valid  <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_data_a <= w_rd_a;
                r_rd_data_b <= w_rd_b;
            end
        end
    end

    // A new illegal enable outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_err <= 1'b0;
        end else if (w_multi_hot) begin
            r_wr_err <= 1'b1;
        end else if (err_clr) begin
            r_wr_err <= 1'b0;
        end
    end

    assign rd_data_a = r_rd_data_a;
    assign rd_data_b = r_rd_data_b;
    assign rd_valid  = r_rd_valid;
    assign wr_err    = r_wr_err;

endmodule
